// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side end of the store/load request channel. It takes one request
//   at a time, waits WAIT_STATES cycles, commits the access into a
//   word-addressed array, and then presents a single-cycle response.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   req_valid       request present
//   req_ready       high in IDLE only
//   req_write       1 = store, 0 = load
//   address         32-bit word address
//   write_data      store data
//   resp_valid      one-cycle response pulse (RESP state)
//   mem_read_data   load result; zero for stores and out-of-range accesses
//   resp_error      address >= DEPTH
//   busy            request accepted but not yet responded (WAIT or RESP)
//   dbg_state       current FSM state, for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. Request inputs are ignored while req_ready is 0.
// The response has no backpressure: resp_valid is high for exactly one
// cycle.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] mem_read_data,
  output logic        resp_error,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_commit;
  logic          w_c_write;
  logic [31:0]   w_c_addr;
  logic [31:0]   w_c_wdata;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // With no wait states the commit happens on the accept edge itself, so the
  // commit operands come straight from the request inputs in that case.
  assign w_commit = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                    (w_accept && (WAIT_STATES == 0));

  assign w_c_write = (r_state == S_IDLE) ? req_write  : r_write;
  assign w_c_addr  = (r_state == S_IDLE) ? address    : r_addr;
  assign w_c_wdata = (r_state == S_IDLE) ? write_data : r_wdata;

  // Full 32-bit compare: high address bits never alias into the array.
  assign w_in_range = (w_c_addr < 32'(DEPTH));
  assign w_idx      = w_c_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= address;
            r_wdata <= write_data;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CW'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_commit) begin
        if (!w_in_range) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else begin
          r_err <= 1'b0;
          if (w_c_write) begin
            r_mem[w_idx] <= w_c_wdata;
            r_rdata      <= '0;
          end else begin
            r_rdata <= r_mem[w_idx];
          end
        end
      end
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign busy          = (r_state != S_IDLE);
  assign mem_read_data = r_rdata;
  assign resp_error    = r_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int WA = 1;
  localparam int WB = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // instance A (WAIT_STATES=1)
  logic        a_valid, a_write, a_ready, a_rv, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_st;
  // instance B (WAIT_STATES=0)
  logic        b_valid, b_write, b_ready, b_rv, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_st;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(WA)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .address(a_addr), .write_data(a_wdata),
    .resp_valid(a_rv), .mem_read_data(a_rdata), .resp_error(a_err),
    .busy(a_busy), .dbg_state(a_st)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(WB)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .address(b_addr), .write_data(b_wdata),
    .resp_valid(b_rv), .mem_read_data(b_rdata), .resp_error(b_err),
    .busy(b_busy), .dbg_state(b_st)
  );

  // scoreboard: {error, data} expected per accepted request plus accept edge
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];
  int          acc_q_a[$];
  int          acc_q_b[$];
  logic [31:0] model [logic [32:0]];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // response monitors
  always @(negedge clk) begin
    logic [32:0] e;
    int          acc;
    if (rst_n === 1'b1 && a_rv === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        check("a_unexpected_resp", 32'(exp_q_a.size()), 32'd1);
      end else begin
        e   = exp_q_a.pop_front();
        acc = acc_q_a.pop_front();
        check("a_rdata", a_rdata, e[31:0]);
        check("a_err", {31'b0, a_err}, {31'b0, e[32]});
        check("a_latency", 32'(cyc - acc), 32'(WA));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    int          acc;
    if (rst_n === 1'b1 && b_rv === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        check("b_unexpected_resp", 32'(exp_q_b.size()), 32'd1);
      end else begin
        e   = exp_q_b.pop_front();
        acc = acc_q_b.pop_front();
        check("b_rdata", b_rdata, e[31:0]);
        check("b_err", {31'b0, b_err}, {31'b0, e[32]});
        check("b_latency", 32'(cyc - acc), 32'(WB));
      end
    end
  end

  // driver: called just after a negedge; returns just after the negedge that
  // follows the accept edge. hold keeps req_valid high; track=0 means the
  // request will be discarded (no expectation, no model update).
  task automatic send(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input bit hold, input bit track,
                      output int acc);
    logic [32:0] e;
    logic [32:0] key;
    int          guard;
    if (!sel) begin
      a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = data;
    end else begin
      b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = data;
    end
    guard = 0;
    while (((sel ? b_ready : a_ready) !== 1'b1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      check(sel ? "b_accept_timeout" : "a_accept_timeout", 32'(guard), 32'd0);
      acc = -1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (track) begin
      key = {sel, addr};
      if (addr >= 32'd256) begin
        e = {1'b1, 32'h0};
      end else if (wr) begin
        e = {1'b0, 32'h0};
        model[key] = data;
      end else begin
        e = {1'b0, model.exists(key) ? model[key] : 32'h0};
      end
      if (!sel) begin exp_q_a.push_back(e); acc_q_a.push_back(acc); end
      else      begin exp_q_b.push_back(e); acc_q_b.push_back(acc); end
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      if (!sel) a_valid = 1'b0;
      else      b_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit sel);
    int guard;
    guard = 0;
    while (((sel ? exp_q_b.size() : exp_q_a.size()) != 0 ||
            (sel ? b_busy : a_busy) !== 1'b0) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check(sel ? "b_idle_timeout" : "a_idle_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, ex;
    rst_n   = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_a_ready", {31'b0, a_ready}, 32'd1);
    check("rst_a_rv",    {31'b0, a_rv},    32'd0);
    check("rst_a_busy",  {31'b0, a_busy},  32'd0);
    check("rst_a_rdata", a_rdata,          32'd0);
    check("rst_a_err",   {31'b0, a_err},   32'd0);
    check("rst_a_state", {30'b0, a_st},    32'd0);
    check("rst_b_ready", {31'b0, b_ready}, 32'd1);
    check("rst_b_rdata", b_rdata,          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic store/load and read-after-write
    send(0, 1, 32'd55, 32'h56, 0, 1, ex);
    check("a_busy_wait", {31'b0, a_busy}, 32'd1);
    check("a_ready_wait", {31'b0, a_ready}, 32'd0);
    wait_idle(0);
    send(0, 1, 32'd66, 32'h36, 0, 1, ex); wait_idle(0);
    send(0, 0, 32'd55, 32'h0,  0, 1, ex); wait_idle(0);
    check("a_rdata_hold", a_rdata, 32'h56);
    send(0, 0, 32'd66, 32'h0,  0, 1, ex); wait_idle(0);

    // back-to-back with req_valid held
    send(0, 0, 32'd55, 32'h0, 1, 1, e1);
    send(0, 0, 32'd66, 32'h0, 0, 1, e2);
    check("a_b2b_gap", 32'(e2 - e1), 32'(WA + 2));
    wait_idle(0);

    // range boundaries
    send(0, 1, 32'd44,  32'h44,   0, 1, ex);
    send(0, 1, 32'd300, 32'hDEAD, 0, 1, ex);
    send(0, 0, 32'd300, 32'h0,    0, 1, ex);
    send(0, 0, 32'd44,  32'h0,    0, 1, ex);
    send(0, 1, 32'd255, 32'hFF,   0, 1, ex);
    send(0, 0, 32'd255, 32'h0,    0, 1, ex);
    send(0, 0, 32'd256, 32'h0,    0, 1, ex);
    send(0, 0, 32'hFFFF_FFFF, 32'h0, 0, 1, ex);
    wait_idle(0);

    // request-channel activity while busy is ignored
    send(0, 1, 32'd20, 32'h77, 0, 1, ex);
    a_valid = 1'(($urandom_range(0, 1))); a_write = 1'b1; a_addr = 32'd55; a_wdata = $urandom;
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'd55; a_wdata = $urandom;
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle(0);
    send(0, 0, 32'd55, 32'h0, 0, 1, ex); wait_idle(0);
    send(0, 0, 32'd20, 32'h0, 0, 1, ex); wait_idle(0);

    // reset during WAIT discards the store
    send(0, 1, 32'd10, 32'h11, 0, 1, ex); wait_idle(0);
    send(0, 0, 32'd10, 32'h0,  0, 1, ex); wait_idle(0);
    send(0, 1, 32'd10, 32'h22, 0, 0, ex);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'b0, a_busy},  32'd0);
    check("arst_ready", {31'b0, a_ready}, 32'd1);
    check("arst_rv",    {31'b0, a_rv},    32'd0);
    check("arst_rdata", a_rdata,          32'd0);
    check("arst_err",   {31'b0, a_err},   32'd0);
    check("arst_state", {30'b0, a_st},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 0, 32'd10, 32'h0, 0, 1, ex); wait_idle(0);

    // zero wait states, back-to-back
    send(1, 1, 32'd3, 32'hA5, 1, 1, e1);
    send(1, 0, 32'd3, 32'h0,  0, 1, e2);
    check("b_b2b_gap", 32'(e2 - e1), 32'(WB + 2));
    wait_idle(1);

    check("a_q_drain", 32'(exp_q_a.size()), 32'd0);
    check("b_q_drain", 32'(exp_q_b.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
